// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin owner selection for an 8-way decoded resource.
// One requester owns the resource at a time; it keeps the grant until it pulses
// done or drops its request. The scan for the next owner starts one past the
// previous owner, so every active requester is served in turn, and an IDLE
// cycle with no grant always separates two owners.
//
// Optional feature (macro RR_SEL_ARBITER_TIMEOUT_EN): a hold counter force-
// releases a grant after MAX_HOLD busy cycles and pulses timeout for one cycle.
// With the macro undefined no counter exists and timeout is tied low.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no owner; arbitrate among req on the next edge
// ST_BUSY | sel/grant held for the owner until done, drop or expiry

module rr_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t     state_q;
    logic [2:0] sel_q;
    logic [2:0] last_ptr_q;
    logic [7:0] grant_q;
    logic       valid_q;

    logic [2:0] win_d;
    logic       win_found;
    logic [2:0] scan_idx;
    logic       rel_norm;
    logic       expire;

    // Out-of-range hold limits are rejected at elaboration.
    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_sel_arbiter: MAX_HOLD must be in 2..256");
    end

    // Winner search: first set request starting one past the last owner,
    // wrapping naturally in 3 bits; the last owner itself is checked last.
    always_comb begin
        win_d     = 3'd0;
        win_found = 1'b0;
        scan_idx  = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            scan_idx = last_ptr_q + 3'(i);
            if (!win_found && req[scan_idx]) begin
                win_d     = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    // Release by the owner: explicit done or withdrawal of its own request.
    assign rel_norm = done || !req[sel_q];

`ifdef RR_SEL_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MAX_HOLD);

    logic [CW-1:0] hold_q;
    logic          timeout_q;

    // hold_q counts completed busy cycles; the last one reaches MAX_HOLD-1.
    assign expire  = (hold_q == CW'(MAX_HOLD - 1));
    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 3'd0;
            last_ptr_q <= 3'd7;
            grant_q    <= 8'h00;
            valid_q    <= 1'b0;
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
            hold_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                    if (win_found) begin
                        sel_q   <= win_d;
                        grant_q <= 8'd1 << win_d;
                        valid_q <= 1'b1;
                        state_q <= ST_BUSY;
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (rel_norm || expire) begin
                        grant_q    <= 8'h00;
                        valid_q    <= 1'b0;
                        last_ptr_q <= sel_q;
                        state_q    <= ST_IDLE;
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
                        // A release the owner asked for is never reported as a timeout.
                        timeout_q  <= expire && !rel_norm;
`endif
                    end else begin
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
                        hold_q     <= hold_q + CW'(1);
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign gnt_valid = valid_q;

endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Round-robin arbiter that shares one 8-way decoded resource between eight requesters. It picks one requester per grant, drives the 3-bit select code and the matching registered one-hot grant, and holds that grant until the owner releases it. It sits in front of the 3-to-8 select decoder datapath and is the only block allowed to change the select code. Every select code 0..7 is legal and fully decoded.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held when the timeout feature is compiled in; legal range 2..256.
- `sys_clk`  in  1  system clock; all state changes on the rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request vector; bit i high = requester i wants the resource; level-sensitive.
- `done`  in  1  release strobe from the current owner; sampled only in BUSY.
- `sel`  out  3  registered select code of the current or most recent owner.
- `grant`  out  8  registered one-hot grant, equal to `1 << sel` while `gnt_valid` is high, else 8'h00.
- `gnt_valid`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse when a grant is force-released; constant 0 when the timeout feature is not compiled in.

## Operation
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - State = IDLE.
  - `sel` = 3'd0, `grant` = 8'h00, `gnt_valid` = 0, `timeout` = 0.
  - Internal `last_ptr` = 3'd7; hold counter = 0.
- Pointer rule: the scan starts at `last_ptr + 1` with natural 3-bit wrap (7 wraps to 0). The winner is the first set `req` bit found in that order.
- **IDLE**
  - If `req` != 0: register `sel` = winner, `grant` = `1 << winner`, `gnt_valid` = 1, clear the hold counter, go to BUSY.
  - Else: stay in IDLE; `sel` holds its value and `grant` stays 8'h00.
  - `done` is ignored in IDLE.
- **BUSY**: release occurs when any of these is true:
  - `done` = 1;
  - `req[sel]` = 0 (the owner withdrew);
  - timeout expiry (timeout feature only).
- On release:
  - `grant` = 8'h00, `gnt_valid` = 0, `last_ptr` = `sel`; `sel` holds its value; go to IDLE.
  - More than one release cause in the same cycle is a single release.
- The IDLE state guarantees at least one cycle with `grant` = 8'h00 between two owners. The same requester may win again only if no other requester is active at re-arbitration.
- Requests from non-owners during BUSY have no effect until IDLE.

## Timing
- Grant latency: `req` first high at rising edge N (IDLE) -> `grant`/`gnt_valid` high after edge N.
- Release latency: `done` high at edge M -> `grant` low after edge M. The earliest next grant is after edge M+1.
- Minimum grant length: 1 cycle. Minimum turnaround between owners: 1 idle cycle.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- The hold counter increments on each BUSY cycle without release. Expiry occurs on the edge that ends the `MAX_HOLD`-th BUSY cycle.

## Configuration
- Macro: `RR_SEL_ARBITER_TIMEOUT_EN`.
- Defined:
  - A hold counter of width `$clog2(MAX_HOLD)` is instantiated.
  - A grant not released by `done` or request drop is force-released after `MAX_HOLD` cycles.
  - `timeout` pulses high for exactly the one cycle following the forced release edge, aligned with `grant` going low.
  - If `done` and expiry coincide, the release counts as normal and `timeout` stays 0.
- Undefined: no counter is built, `timeout` is tied to 0, and a grant is held indefinitely until `done` or `req[sel]` drops.

## Test plan
- Reset then single request: `req` = 8'h01 -> the next cycle gives `sel` = 0, `grant` = 8'h01, `gnt_valid` = 1; pulsing `done` for 1 cycle -> `grant` = 8'h00 the next cycle, and `sel` stays 0.
- Rotation: `req` = 8'hFF held with `done` pulsed on every grant -> `sel` sequence 0,1,2,...,7,0 with one idle cycle between grants; `grant` = 8'h80 when `sel` = 7.
- Wrap/skip: last owner 6, `req` = 8'h21 -> next owner 0, then 5.
- Owner withdrawal: owner 3 drops `req[3]` with `done` = 0 -> `grant` = 8'h00 the next cycle and `last_ptr` = 3. A pending `req[4]` is granted one cycle later.
- Reset mid-grant: assert `sys_rst_n` = 0 while `grant` = 8'h10 -> `grant` = 8'h00, `sel` = 0, `gnt_valid` = 0 immediately, without waiting for an edge. After release, `req` = 8'hFF is granted to requester 0.
- With `RR_SEL_ARBITER_TIMEOUT_EN` and `MAX_HOLD` = 4: `req` = 8'h04 held and no `done` -> grant held for 4 cycles, then `grant` = 8'h00 with a 1-cycle `timeout` pulse, and requester 2 is re-granted after 1 idle cycle. Without the macro, the grant is held for 100+ cycles and `timeout` stays 0.
